// File: rtl/countdown_pkg.sv
// Shared constants for the mm:ss BCD countdown: FSM encoding, digit limits,
// bus field offsets and the preset clamp helper.
package countdown_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOADED  = 3'd1;
    localparam state_t ST_RUN     = 3'd2;
    localparam state_t ST_PAUSE   = 3'd3;
    localparam state_t ST_EXPIRED = 3'd4;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

    localparam int SEC_ONES_LSB = 0;
    localparam int SEC_TENS_LSB = 4;
    localparam int MIN_ONES_LSB = 8;
    localparam int MIN_TENS_LSB = 12;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/countdown_ctrl_digit.sv
// One BCD down-counter digit: synchronous load, decrement on enable,
// wrap to MAX with a borrow out that enables the next-higher digit.
module bcd_down_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk_50MHz_i,
    input  logic       rst_async_la_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic [3:0] digit_o,
    output logic       borrow_o
);

    logic [3:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i)
            digit_d = load_val_i;
        else if (en_i)
            digit_d = (digit_q == 4'd0) ? MAX : digit_q - 4'd1;
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i)
            digit_q <= 4'd0;
        else
            digit_q <= digit_d;
    end

    assign digit_o  = digit_q;
    assign borrow_o = en_i && (digit_q == 4'd0);

endmodule

// File: rtl/countdown_ctrl.sv
// mm:ss countdown sequencer: 1 Hz prescaler, run/pause/expire FSM and
// preset clamping in front of a four-digit cascaded BCD down-counter.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int PW       = 26
) (
    input  logic        clk_50MHz_i,
    input  logic        rst_async_la_i,
    input  logic        load_i,
    input  logic        start_i,
    input  logic        pause_i,
    input  logic [15:0] preset_i,
    output logic [15:0] count_o,
    output logic        running_o,
    output logic        tick_o,
    output logic        expired_o,
    output logic        done_o
);

    localparam logic [PW-1:0] RELOAD = PW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          expired_q;
    logic [15:0]   count;
    logic [15:0]   load_val;
    logic [4:0]    en;
    logic          tick, count_zero, last_sec;

    assign count_zero = (count == 16'h0000);
    assign last_sec   = (count == 16'h0001);
    // Gating on a non-zero count keeps the chain from ever underflowing.
    assign tick       = (state_q == ST_RUN) && (presc_q == '0) && !count_zero;
    assign en[0]      = tick && !load_i;

    assign load_val[SEC_ONES_LSB +: 4] = clamp_digit(preset_i[SEC_ONES_LSB +: 4], ONES_MAX);
    assign load_val[SEC_TENS_LSB +: 4] = clamp_digit(preset_i[SEC_TENS_LSB +: 4], TENS_MAX);
    assign load_val[MIN_ONES_LSB +: 4] = clamp_digit(preset_i[MIN_ONES_LSB +: 4], ONES_MAX);
    assign load_val[MIN_TENS_LSB +: 4] = clamp_digit(preset_i[MIN_TENS_LSB +: 4], TENS_MAX);

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_down_digit #(
            .MAX((i % 2 == 0) ? ONES_MAX : TENS_MAX)
        ) u_digit (
            .clk_50MHz_i   (clk_50MHz_i),
            .rst_async_la_i(rst_async_la_i),
            .load_i        (load_i),
            .load_val_i    (load_val[i*4 +: 4]),
            .en_i          (en[i]),
            .digit_o       (count[i*4 +: 4]),
            .borrow_o      (en[i+1])
        );
    end

    always_comb begin
        state_d = state_q;
        if (load_i)
            state_d = ST_LOADED;
        // A borrow out of the top digit would be an underflow; treat it as expiry.
        else if (state_q == ST_RUN && ((tick && last_sec) || en[4]))
            state_d = ST_EXPIRED;
        else if (pause_i && state_q == ST_RUN)
            state_d = ST_PAUSE;
        else if (start_i && (state_q == ST_LOADED || state_q == ST_PAUSE))
            state_d = count_zero ? ST_EXPIRED : ST_RUN;
    end

    // Prescaler holds outside RUN so a paused partial second survives resume.
    always_comb begin
        presc_d = presc_q;
        if (load_i)
            presc_d = RELOAD;
        else if (state_q == ST_RUN)
            presc_d = (presc_q == '0) ? RELOAD : presc_q - PW'(1);
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            state_q   <= ST_IDLE;
            presc_q   <= RELOAD;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            expired_q <= (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
        end
    end

    assign count_o   = count;
    assign running_o = (state_q == ST_RUN);
    assign tick_o    = tick;
    assign expired_o = expired_q;
    assign done_o    = (state_q == ST_EXPIRED);

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for a four-digit mm:ss BCD countdown built from cascaded mod-N down-counter digits. It divides the 50 MHz clock into a 1 Hz tick, loads a preset time, and runs, pauses or stops the digit chain through a small FSM. At 00:00 it flags expiry. It sits between the game-logic/button interface and the seven-segment display driver.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per tick; the bench uses 4.
- `PW`, default 26: prescaler width; must satisfy 2^PW ≥ TICK_DIV.
- `clk_50MHz_i` in 1: system clock, rising edge.
- `rst_async_la_i` in 1: reset, asynchronous, active-low.
- `load_i` in 1: one-cycle pulse that captures the preset digits.
- `start_i` in 1: one-cycle pulse that begins or resumes the countdown.
- `pause_i` in 1: one-cycle pulse that freezes the countdown.
- `preset_i` in 16: BCD preset, packed {min_tens, min_ones, sec_tens, sec_ones}.
- `count_o` out 16: current BCD time, same packing.
- `running_o` out 1: high while in state RUN.
- `tick_o` out 1: one-cycle pulse on each countdown step.
- `expired_o` out 1: one-cycle pulse when 00:00 is reached.
- `done_o` out 1: level, high in state EXPIRED.

## Operation
- States: IDLE, LOADED, RUN, PAUSE, EXPIRED. Reset enters IDLE.
- **Reset values:** `count_o` = 0x0000; all flags 0; prescaler = TICK_DIV-1.
- **Command priority** when pulses coincide: `load_i` > `pause_i` > `start_i`.
- **`load_i` in any state:**
  - Capture `preset_i` into `count_o` with clamping: ones digits >9 become 9; tens digits >5 become 5.
  - Reload the prescaler to TICK_DIV-1 and go to LOADED.
- **`start_i`:**
  - LOADED or PAUSE → RUN.
  - If the count is 0x0000, go to EXPIRED instead.
  - Ignored in IDLE, RUN and EXPIRED.
- **`pause_i`:** RUN → PAUSE; ignored in all other states.
- **Prescaler:**
  - Decrements only in RUN.
  - On reaching 0 it asserts `tick_o` and reloads to TICK_DIV-1.
  - In PAUSE it holds its value, so the partial second is preserved on resume.
- **Digit chain on a tick:**
  - `sec_ones` decrements.
  - Each digit's borrow (digit == 0 while enabled) wraps that digit to its max (9 for ones, 5 for tens) and enables the next-higher digit.
  - Example: 10:00 → 09:59.
- **Reaching zero:**
  - A tick that makes the count 0x0000 moves the FSM to EXPIRED on the same edge.
  - `expired_o` pulses for that cycle only, never again until a new load.
- **EXPIRED:** count holds at 0x0000; `done_o` = 1. Exit only via `load_i` or reset.
- **Underflow:** the count never goes below 00:00. A tick is never issued while the count is 0.

## Timing
- **`load_i` to `count_o`:** captured preset visible the next cycle; 1 clk latency.
- **`start_i`:** `running_o` rises the next cycle. The first tick follows TICK_DIV cycles after the `start_i` edge, when starting from LOADED.
- **`tick_o` to `count_o`:** `tick_o` is high for one cycle; `count_o` updates on the edge that ends that cycle.
- **Expiry:** `expired_o` and the rise of `done_o` appear in the same cycle, 1 cycle after the final tick.
- **`pause_i` during the tick cycle:** the decrement still completes; the FSM then enters PAUSE.
- **`load_i` during the tick cycle:** the load wins; no decrement is applied.
- **Reset mid-run:** outputs return immediately (asynchronously) to reset values.

## Structure
- **Package `countdown_pkg`:**
  - State enum.
  - Digit max constants: ONES_MAX = 9, TENS_MAX = 5.
  - Packed field offsets for the 16-bit BCD bus.
- **Sub-module `bcd_down_digit`** (parameter MAX):
  - One digit with enable in, borrow out, synchronous load, wrap to MAX.
  - Instantiated four times.
- **Top level:** FSM, prescaler, load clamping.

## Test plan
- **Basic countdown:** TICK_DIV=4; load 0x0003, start → ticks every 4 clk; count 0003→0002→0001→0000; `expired_o` is a single pulse; `done_o` stays 1.
- **Borrow cascade:** load 0x1000, start → after one tick `count_o` = 0x0959.
- **Clamping:** load 0x7F9C → `count_o` = 0x5959.
- **Pause/resume:** pause 2 clk into a 4-clk tick period, wait 20 clk → count unchanged; start → next tick occurs exactly 2 clk later.
- **Zero start and priority:** start with count 0x0000 → EXPIRED the next cycle; `load_i`+`pause_i`+`start_i` in the same cycle during RUN → LOADED, count = preset.
- **Async reset:** drop reset mid-RUN at count 0x0042 → `count_o` = 0 and `running_o` = 0 without a clock edge; FSM in IDLE, where `start_i` is ignored.
